// File: rtl/chain_result_uart_framer.sv
// chain_result_uart_framer: queues chain-code Encoder results in a small FIFO and
// streams each one as a checksummed byte frame over the UART_Transmit
// T_EN / Data / Transmit_Done handshake.
module chain_result_uart_framer #(
  parameter int unsigned COORD_W   = 8,
  parameter int unsigned AREA_W    = 16,
  parameter int unsigned PERIM_W   = 16,
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               res_valid,
  input  logic               res_error,
  input  logic [COORD_W-1:0] res_x,
  input  logic [COORD_W-1:0] res_y,
  input  logic [AREA_W-1:0]  res_area,
  input  logic [PERIM_W-1:0] res_perim,
  output logic               res_ready,
  output logic               overflow,
  output logic               T_EN,
  output logic [7:0]         Data,
  input  logic               Transmit_Done,
  output logic               busy,
  output logic [15:0]        frames_sent
);

  // Field sizes rounded up to whole bytes, zero-extended at the MSB end
  localparam int unsigned XB        = (COORD_W + 7) / 8;
  localparam int unsigned AB        = (AREA_W + 7) / 8;
  localparam int unsigned PB        = (PERIM_W + 7) / 8;
  localparam int unsigned XBITS     = XB * 8;
  localparam int unsigned ABITS     = AB * 8;
  localparam int unsigned PBITS     = PB * 8;
  localparam int unsigned PAY_BYTES = 1 + 2 * XB + AB + PB;
  localparam int unsigned FRAME_LEN = PAY_BYTES + 2;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef struct packed {
    logic               err;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [AREA_W-1:0]  area;
    logic [PERIM_W-1:0] perim;
  } entry_t;

  entry_t                 mem [DEPTH];
  entry_t                 shadow;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_d;
  logic                   full_c;
  logic                   push_c;
  logic                   pop_c;
  logic                   frame_done_c;

  logic [2:0]             state;
  logic [2:0]             state_d;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_d;
  logic [IDX_W-1:0]       idx_inc_c;
  logic                   t_en_d;
  logic [7:0]             data_d;
  logic [6:0]             seq;

  logic [PAY_BYTES*8-1:0] payload_c;
  logic [FRAME_LEN*8-1:0] frame_c;
  logic [7:0]             csum_c;
  logic [7:0]             next_byte_c;

  assign full_c    = (count == CNT_W'(DEPTH));
  assign push_c    = res_valid && !full_c;
  assign count_d   = count + CNT_W'(push_c) - CNT_W'(pop_c);
  assign idx_inc_c = idx + IDX_W'(1);

  // FIFO storage and the shadow copy of the result being framed
  always_ff @(posedge Clk) begin
    if (push_c) begin
      mem[wr_ptr] <= {res_error, res_x, res_y, res_area, res_perim};
    end
    if (pop_c) begin
      shadow <= mem[rd_ptr];
    end
  end

  // FIFO pointers, occupancy, ready and sticky overflow
  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_ready <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_d;
      res_ready <= (count_d != CNT_W'(DEPTH));
      if (res_valid && full_c) overflow <= 1'b1;
    end
  end

  // Frame image of the shadow entry, checksum, and the byte after idx
  always_comb begin
    payload_c = {seq, shadow.err, XBITS'(shadow.x), XBITS'(shadow.y),
                 ABITS'(shadow.area), PBITS'(shadow.perim)};
    csum_c = 8'h00;
    for (int unsigned i = 0; i < PAY_BYTES; i++) begin
      csum_c = csum_c + payload_c[i*8 +: 8];
    end
    frame_c = {SYNC_BYTE, payload_c, csum_c};
    next_byte_c = 8'h00;
    for (int unsigned i = 0; i < FRAME_LEN; i++) begin
      if (idx_inc_c == IDX_W'(i)) begin
        next_byte_c = frame_c[(FRAME_LEN-1-i)*8 +: 8];
      end
    end
  end

  // Next-state and registered-output values for the framing FSM
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    t_en_d       = T_EN;
    data_d       = Data;
    pop_c        = 1'b0;
    frame_done_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        pop_c   = 1'b1;
        idx_d   = '0;
        t_en_d  = 1'b1;
        data_d  = SYNC_BYTE;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (Transmit_Done) begin
          t_en_d  = 1'b0;
          state_d = (idx == IDX_W'(FRAME_LEN-1)) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        idx_d   = idx_inc_c;
        t_en_d  = 1'b1;
        data_d  = next_byte_c;
        state_d = S_SEND;
      end
      S_DONE: begin
        frame_done_c = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, UART handshake outputs, frame and sequence counters
  always_ff @(posedge Clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      T_EN        <= 1'b0;
      Data        <= 8'h00;
      busy        <= 1'b0;
      frames_sent <= 16'h0000;
      seq         <= 7'd0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      T_EN  <= t_en_d;
      Data  <= data_d;
      busy  <= (state_d != S_IDLE);
      if (frame_done_c) begin
        frames_sent <= frames_sent + 16'd1;
        seq         <= seq + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_chain_result_uart_framer.sv
// Bench for chain_result_uart_framer: directed results, a UART responder per
// instance, and monitors that pop expected bytes from scoreboard queues.
`timescale 1ns/1ps
module tb_chain_result_uart_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  // default instance
  logic        res_valid = 1'b0, res_error = 1'b0;
  logic [7:0]  res_x = '0, res_y = '0;
  logic [15:0] res_area = '0, res_perim = '0;
  logic        res_ready, overflow, t_en, busy, tdone_a;
  logic [7:0]  data;
  logic [15:0] frames_sent;
  logic        td_a = 1'b0, stray = 1'b0, hold = 1'b0;
  assign tdone_a = td_a | stray;

  // wide-field instance
  logic        res_valid_b = 1'b0, res_error_b = 1'b0;
  logic [9:0]  res_x_b = '0, res_y_b = '0;
  logic [19:0] res_area_b = '0;
  logic [15:0] res_perim_b = '0;
  logic        res_ready_b, overflow_b, t_en_b, busy_b;
  logic        td_b = 1'b0;
  logic [7:0]  data_b;
  logic [15:0] frames_sent_b;

  chain_result_uart_framer dut_a (
    .Clk(clk), .reset(reset), .res_valid(res_valid), .res_error(res_error),
    .res_x(res_x), .res_y(res_y), .res_area(res_area), .res_perim(res_perim),
    .res_ready(res_ready), .overflow(overflow), .T_EN(t_en), .Data(data),
    .Transmit_Done(tdone_a), .busy(busy), .frames_sent(frames_sent)
  );

  chain_result_uart_framer #(.COORD_W(10), .AREA_W(20)) dut_b (
    .Clk(clk), .reset(reset), .res_valid(res_valid_b), .res_error(res_error_b),
    .res_x(res_x_b), .res_y(res_y_b), .res_area(res_area_b), .res_perim(res_perim_b),
    .res_ready(res_ready_b), .overflow(overflow_b), .T_EN(t_en_b), .Data(data_b),
    .Transmit_Done(td_b), .busy(busy_b), .frames_sent(frames_sent_b)
  );

  typedef struct {
    logic [7:0] b;
    int         idx;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_idx_a = -1;
  logic [6:0] tb_seq = 7'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART model for instance A: Done pulse after three T_EN cycles unless held
  initial begin
    int w;
    w = 0;
    forever begin
      @(posedge clk); #1;
      if (td_a) td_a = 1'b0;
      else if (t_en && !hold) begin
        if (w >= 2) begin td_a = 1'b1; w = 0; end
        else w++;
      end else w = 0;
    end
  end

  // UART model for instance B
  initial begin
    int w;
    w = 0;
    forever begin
      @(posedge clk); #1;
      if (td_b) td_b = 1'b0;
      else if (t_en_b) begin
        if (w >= 1) begin td_b = 1'b1; w = 0; end
        else w++;
      end else w = 0;
    end
  end

  // Monitor A: byte values, Data stability under T_EN, one-cycle inter-byte gap
  initial begin
    logic       p_ten;
    logic [7:0] p_data;
    int         low;
    exp_t       e;
    p_ten = 1'b0; p_data = '0; low = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_ten = 1'b0; low = 0;
      end else begin
        if (t_en && !p_ten) begin
          if (qa.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_byte_a: got %02h expected none at %0t", data, $time);
          end else begin
            e = qa.pop_front();
            check($sformatf("byte_a[%0d]", e.idx), 32'(data), 32'(e.b));
            if (e.idx != 0) check("gap_a", low, 1);
            cur_idx_a = e.idx;
          end
        end else if (t_en && p_ten) begin
          check("stable_a", 32'(data), 32'(p_data));
        end
        low    = t_en ? 0 : low + 1;
        p_ten  = t_en;
        p_data = data;
      end
    end
  end

  // Monitor B: byte values only
  initial begin
    logic p_ten;
    exp_t e;
    p_ten = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) p_ten = 1'b0;
      else begin
        if (t_en_b && !p_ten) begin
          if (qb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_byte_b: got %02h expected none at %0t", data_b, $time);
          end else begin
            e = qb.pop_front();
            check($sformatf("byte_b[%0d]", e.idx), 32'(data_b), 32'(e.b));
          end
        end
        p_ten = t_en_b;
      end
    end
  end

  task automatic push_a(input logic err, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] a, input logic [15:0] p);
    res_valid = 1'b1; res_error = err; res_x = x; res_y = y; res_area = a; res_perim = p;
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic exp_frame_a(input logic err, input logic [7:0] x, input logic [7:0] y,
                             input logic [15:0] a, input logic [15:0] p);
    logic [7:0] b [9];
    logic [7:0] cs;
    b[0] = 8'hA5; b[1] = {tb_seq, err}; b[2] = x; b[3] = y;
    b[4] = a[15:8]; b[5] = a[7:0]; b[6] = p[15:8]; b[7] = p[7:0];
    cs = 8'h00;
    for (int i = 1; i < 8; i++) cs = cs + b[i];
    b[8] = cs;
    for (int i = 0; i < 9; i++) qa.push_back('{b[i], i});
    tb_seq = tb_seq + 7'd1;
  endtask

  task automatic send_a(input logic err, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] a, input logic [15:0] p);
    exp_frame_a(err, x, y, a, p);
    push_a(err, x, y, a, p);
  endtask

  task automatic drain_a(input string name);
    int k;
    k = 0;
    while ((qa.size() != 0 || busy || t_en) && k < 20000) begin
      @(posedge clk); #1; k++;
    end
    check({name, "_drained"}, 32'(qa.size() == 0 && !busy), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [9] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h01, 8'h02, 8'h00, 8'h10, 8'h59};
    logic [7:0] t2 [9] = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h01, 8'h02, 8'h00, 8'h10, 8'h5C};
    logic [7:0] tb6 [12] = '{8'hA5, 8'h00, 8'h03, 8'hFF, 8'h01, 8'h55,
                             8'h0A, 8'hBC, 8'hDE, 8'h12, 8'h34, 8'h42};
    int k;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_ready", 32'(res_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_t_en", 32'(t_en), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: first frame, with request latency
    for (int i = 0; i < 9; i++) qa.push_back('{t1[i], i});
    tb_seq = 7'd1;
    push_a(1'b0, 8'h12, 8'h34, 16'h0102, 16'h0010);
    @(posedge clk); #1;
    check("lat_load_busy", 32'(busy), 32'd1);
    check("lat_load_t_en", 32'(t_en), 32'd0);
    @(posedge clk); #1;
    check("lat_send_t_en", 32'(t_en), 32'd1);
    check("lat_send_data", 32'(data), 32'hA5);
    drain_a("t1");
    check("t1_frames", 32'(frames_sent), 32'd1);

    // 2: error flag and sequence number in FLAGS
    for (int i = 0; i < 9; i++) qa.push_back('{t2[i], i});
    tb_seq = 7'd2;
    push_a(1'b1, 8'h12, 8'h34, 16'h0102, 16'h0010);
    drain_a("t2");
    check("t2_frames", 32'(frames_sent), 32'd2);

    // 3: stalled UART, fill the FIFO, drop one
    hold = 1'b1;
    send_a(1'b0, 8'h01, 8'h02, 16'h0304, 16'h0506);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) send_a(1'(i), 8'(8'h20 + i), 8'(8'h40 + i), 16'(16'h1000 * i + 7), 16'(16'hF00F - i));
      else push_a(1'b1, 8'hEE, 8'hEE, 16'hEEEE, 16'hEEEE);
      if (i == 3) begin
        check("t3_ready_full", 32'(res_ready), 32'd0);
        check("t3_no_ovf_yet", 32'(overflow), 32'd0);
      end
    end
    check("t3_ready_after_drop", 32'(res_ready), 32'd0);
    check("t3_overflow", 32'(overflow), 32'd1);
    hold = 1'b0;
    drain_a("t3");
    check("t3_frames", 32'(frames_sent), 32'd7);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    check("t3_ready_empty", 32'(res_ready), 32'd1);

    // 4: reset during the fourth byte with two entries queued
    cur_idx_a = -1;
    send_a(1'b0, 8'hA1, 8'hB2, 16'hC3D4, 16'hE5F6);
    send_a(1'b1, 8'h11, 8'h22, 16'h3344, 16'h5566);
    send_a(1'b0, 8'h77, 8'h88, 16'h99AA, 16'hBBCC);
    k = 0;
    while (cur_idx_a != 3 && k < 500) begin @(posedge clk); k++; end
    check("t4_reached_byte4", cur_idx_a, 3);
    #1;
    reset = 1'b1;
    qa.delete();
    @(posedge clk); #1;
    check("t4_t_en", 32'(t_en), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_fifo_empty", 32'(res_ready), 32'd1);
    check("t4_frames", 32'(frames_sent), 32'd0);
    check("t4_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tb_seq = 7'd0;
    @(posedge clk); #1;
    check("t4_stays_idle", 32'(busy), 32'd0);
    send_a(1'b1, 8'h5A, 8'hC3, 16'h0F0F, 16'hF0F0);
    drain_a("t4");
    check("t4_frames_after", 32'(frames_sent), 32'd1);

    // 5: stray Done while idle, then sequence wrap over 128 frames
    @(posedge clk); #1;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    check("t5_stray_busy", 32'(busy), 32'd0);
    check("t5_stray_t_en", 32'(t_en), 32'd0);
    @(posedge clk); #1;
    check("t5_stray_busy2", 32'(busy), 32'd0);
    check("t5_stray_frames", 32'(frames_sent), 32'd1);
    for (int i = 0; i < 128; i++) begin
      k = 0;
      while (!res_ready && k < 1000) begin @(posedge clk); #1; k++; end
      send_a(1'(i), 8'(i), 8'(255 - i), 16'(i * 257), 16'(i ^ 16'h5A5A));
    end
    drain_a("t5");
    check("t5_frames", 32'(frames_sent), 32'd129);
    check("t5_seq_wrapped", 32'(tb_seq), 32'd1);

    // 6: wide fields on the second instance
    for (int i = 0; i < 12; i++) qb.push_back('{tb6[i], i});
    res_valid_b = 1'b1; res_error_b = 1'b0; res_x_b = 10'h3FF; res_y_b = 10'h155;
    res_area_b = 20'hABCDE; res_perim_b = 16'h1234;
    @(posedge clk); #1;
    res_valid_b = 1'b0;
    k = 0;
    while ((qb.size() != 0 || busy_b || t_en_b) && k < 2000) begin @(posedge clk); #1; k++; end
    check("t6_drained", 32'(qb.size() == 0 && !busy_b), 32'd1);
    check("t6_frames", 32'(frames_sent_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
